// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: widths, header field layout and the
// ingress FSM state type.
package router_pkg;

  localparam int DATA_W    = 8;
  localparam int LEN_W     = 6;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY,
    DROP
  } state_t;

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_LEN_LSB +: LEN_W];
  endfunction

endpackage

// File: rtl/router_out_reg.sv
// One-byte holding register feeding the shared FIFO bus; derives the
// one-hot write enable and busy backpressure from the selected FIFO's full flag.
module router_out_reg
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [DATA_W-1:0]    load_data,
  input  logic                 load_lfd,
  input  logic [ADDR_W-1:0]    load_sel,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic [DATA_W-1:0]    data_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic                 busy
);

  logic              out_valid;
  logic              lfd_q;
  logic [ADDR_W-1:0] sel;
  logic              written;

  always_comb begin
    write_enb = '0;
    if (out_valid) begin
      write_enb = NUM_PORTS'(1) << sel;
    end
  end

  // Only the selected FIFO's full flag matters; write_enb is zero elsewhere.
  assign busy      = |(write_enb & fifo_full);
  assign written   = |(write_enb & ~fifo_full);
  assign lfd_state = out_valid & lfd_q;

  always_ff @(posedge clk) begin
    if (resetn) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      lfd_q     <= 1'b0;
      sel       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      data_out  <= load_data;
      lfd_q     <= load_lfd;
      sel       <= load_sel;
    end else if (written) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/router_ingress.sv
// Router input stage: parses header/payload/parity, routes bytes to the
// addressed FIFO through the holding register, and checks packet parity.
module router_ingress
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic [DATA_W-1:0]    data_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic                 parity_done,
  output logic                 err
);

  state_t            state, state_next;
  logic [LEN_W-1:0]  count, count_next;
  logic [DATA_W-1:0] parity, parity_next;
  logic [ADDR_W-1:0] pkt_sel, pkt_sel_next;
  logic              parity_done_next;
  logic              err_next;
  logic              accept;
  logic              load;
  logic              load_lfd;
  logic [ADDR_W-1:0] load_sel;

  assign accept = pkt_valid & ~busy;

  always_comb begin
    state_next       = state;
    count_next       = count;
    parity_next      = parity;
    pkt_sel_next     = pkt_sel;
    parity_done_next = 1'b0;
    err_next         = err;
    load             = 1'b0;
    load_lfd         = 1'b0;
    load_sel         = pkt_sel;
    if (accept) begin
      case (state)
        IDLE: begin
          pkt_sel_next = hdr_addr(data_in);
          count_next   = hdr_len(data_in);
          parity_next  = data_in;
          if (hdr_addr(data_in) == ADDR_INVALID) begin
            state_next = DROP;
          end else begin
            load       = 1'b1;
            load_lfd   = 1'b1;
            load_sel   = hdr_addr(data_in);
            err_next   = 1'b0;
            state_next = (hdr_len(data_in) == '0) ? PARITY : PAYLOAD;
          end
        end
        PAYLOAD: begin
          load        = 1'b1;
          parity_next = parity ^ data_in;
          count_next  = count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          load             = 1'b1;
          parity_done_next = 1'b1;
          err_next         = (parity != data_in);
          state_next       = IDLE;
        end
        DROP: begin
          // Counter starts at len, so len+1 bytes are swallowed after the header.
          if (count == '0) begin
            state_next = IDLE;
          end else begin
            count_next = count - LEN_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state       <= IDLE;
      count       <= '0;
      parity      <= '0;
      pkt_sel     <= '0;
      parity_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      parity      <= parity_next;
      pkt_sel     <= pkt_sel_next;
      parity_done <= parity_done_next;
      err         <= err_next;
    end
  end

  router_out_reg u_out_reg (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .load_data (data_in),
    .load_lfd  (load_lfd),
    .load_sel  (load_sel),
    .fifo_full (fifo_full),
    .data_out  (data_out),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .busy      (busy)
  );

endmodule

// File: tb/tb_router_ingress.sv
// Self-checking bench for router_ingress: packet-level reference model,
// per-cycle output comparison and an in-order FIFO write scoreboard.
module tb_router_ingress;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [7:0] data_out;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic       parity_done;
  logic       err;

  int checks = 0;
  int errors = 0;

  router_ingress dut (
    .clk         (clk),
    .resetn      (resetn),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .data_out    (data_out),
    .write_enb   (write_enb),
    .lfd_state   (lfd_state),
    .parity_done (parity_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks a packet by bytes remaining rather than by state.
  logic       m_ov = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_lfd = 1'b0;
  int         m_port = 0;
  int         m_pkt_port = 0;
  logic       m_inpkt = 1'b0;
  logic       m_drop = 1'b0;
  int         m_rem = 0;
  logic [7:0] m_xor = 8'h00;
  logic       m_err = 1'b0;
  logic       m_pdone = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] act_q[$];

  always @(posedge clk) begin
    logic acc, wr, hdr;
    if (resetn) begin
      m_ov = 1'b0; m_byte = 8'h00; m_lfd = 1'b0; m_port = 0; m_inpkt = 1'b0;
      m_rem = 0; m_xor = 8'h00; m_err = 1'b0; m_pdone = 1'b0;
      exp_q.delete();
    end else begin
      acc = pkt_valid && !(m_ov && fifo_full[m_port]);
      wr  = m_ov && !fifo_full[m_port];
      hdr = !m_inpkt;
      m_pdone = 1'b0;
      if (acc) begin
        if (hdr) begin
          m_pkt_port = int'(data_in[1:0]);
          m_drop     = (m_pkt_port == 3);
          m_rem      = int'(data_in[7:2]) + 1;
          m_xor      = data_in;
          m_inpkt    = 1'b1;
          if (!m_drop) m_err = 1'b0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_inpkt = 1'b0;
            if (!m_drop) begin
              m_pdone = 1'b1;
              m_err   = (m_xor != data_in);
            end
          end else begin
            m_xor = m_xor ^ data_in;
          end
        end
        if (!m_drop) begin
          m_ov = 1'b1; m_byte = data_in; m_port = m_pkt_port; m_lfd = hdr;
          exp_q.push_back({2'(m_pkt_port), data_in});
        end else if (wr) begin
          m_ov = 1'b0;
        end
      end else if (wr) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (resetn) begin
      act_q.delete();
    end else begin
      for (int p = 0; p < 3; p++)
        if (write_enb[p] === 1'b1 && !fifo_full[p]) act_q.push_back({2'(p), data_out});
    end
  end

  int cnt_we0 = 0, cnt_we1 = 0, cnt_we2 = 0, cnt_we_any = 0;
  int cnt_lfd = 0, cnt_pd = 0, cnt_busy = 0, cnt_hold3 = 0;

  always @(negedge clk) begin
    logic [2:0] e_we;
    e_we = m_ov ? 3'(3'b001 << m_port) : 3'b000;
    chk("busy", 32'(busy), 32'(m_ov && fifo_full[m_port]));
    chk("write_enb", 32'(write_enb), 32'(e_we));
    chk("data_out", 32'(data_out), 32'(m_byte));
    chk("lfd_state", 32'(lfd_state), 32'(m_ov && m_lfd));
    chk("parity_done", 32'(parity_done), 32'(m_pdone));
    chk("err", 32'(err), 32'(m_err));
    if (write_enb == 3'b001) cnt_we0++;
    if (write_enb == 3'b010) cnt_we1++;
    if (write_enb == 3'b100) cnt_we2++;
    if (write_enb != 3'b000) cnt_we_any++;
    if (lfd_state) cnt_lfd++;
    if (parity_done) cnt_pd++;
    if (busy) cnt_busy++;
    if (busy && data_out == 8'd3) cnt_hold3++;
  end

  task automatic tick(input logic v, input logic [7:0] d, input logic [2:0] f, output logic acc);
    pkt_valid = v;
    data_in   = d;
    fifo_full = f;
    @(negedge clk);
    acc = v && (busy === 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] f);
    logic acc;
    int n;
    n = 0;
    do begin
      tick(1'b1, d, f, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) tick(1'b0, 8'h00, 3'b000, acc);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] flip);
    logic [7:0] p;
    logic [5:0] len;
    len = hdr[7:2];
    p = hdr;
    send(hdr, 3'b000);
    for (int i = 0; i < int'(len); i++) begin
      send(8'(i), 3'b000);
      p = p ^ 8'(i);
    end
    send(p ^ flip, 3'b000);
  endtask

  task automatic check_queues(input string name);
    chk({name, " write count"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({name, " write"}, 32'(act_q[i]), 32'(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int b0, b1, b2, ba, bl, bp, bb, bh;
    logic acc;
    logic [7:0] len, addr, hdr, p, d;
    logic [2:0] f;

    resetn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("reset write_enb", 32'(write_enb), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Good packet to port 1: header 0x39, payload 0..13, parity 0x38.
    b1 = cnt_we1; bl = cnt_lfd; bp = cnt_pd;
    send_pkt(8'h39, 8'h00);
    idle(3);
    chk("pkt1 port1 write cycles", 32'(cnt_we1 - b1), 32'd16);
    chk("pkt1 lfd cycles", 32'(cnt_lfd - bl), 32'd1);
    chk("pkt1 parity_done pulses", 32'(cnt_pd - bp), 32'd1);
    chk("pkt1 err", 32'(err), 32'd0);
    chk("pkt1 first write", 32'(act_q.size() > 0 ? act_q[0] : 10'h3ff), 32'h139);
    chk("pkt1 parity byte", 32'(act_q.size() == 16 ? act_q[15] : 10'h3ff), 32'h138);
    check_queues("pkt1");

    // Corrupted parity: err rises and stays high.
    bp = cnt_pd;
    send_pkt(8'h39, 8'h01);
    idle(3);
    chk("bad parity_done pulses", 32'(cnt_pd - bp), 32'd1);
    chk("bad err", 32'(err), 32'd1);
    check_queues("bad");

    // Invalid address: dropped silently, err untouched.
    ba = cnt_we_any; bp = cnt_pd; bb = cnt_busy;
    send(8'h0B, 3'b000);
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 3'b000);
    idle(2);
    chk("drop writes", 32'(cnt_we_any - ba), 32'd0);
    chk("drop parity_done", 32'(cnt_pd - bp), 32'd0);
    chk("drop busy", 32'(cnt_busy - bb), 32'd0);
    chk("drop err held", 32'(err), 32'd1);
    check_queues("drop");

    b0 = cnt_we0;
    send_pkt(8'h0C, 8'h00);
    idle(3);
    chk("after drop err cleared", 32'(err), 32'd0);
    chk("after drop port0 writes", 32'(cnt_we0 - b0), 32'd5);
    check_queues("after drop");

    // Backpressure on port 1 after the fourth payload byte is presented.
    bh = cnt_hold3; b1 = cnt_we1;
    send(8'h39, 3'b000);
    p = 8'h39;
    for (int i = 0; i < 14; i++) begin
      send(8'(i), 3'b000);
      p = p ^ 8'(i);
      if (i == 3) repeat (5) tick(1'b1, 8'd4, 3'b010, acc);
    end
    send(p, 3'b000);
    idle(3);
    chk("bp hold cycles", 32'(cnt_hold3 - bh), 32'd5);
    chk("bp err", 32'(err), 32'd0);
    check_queues("bp");

    // Back-to-back: len-0 packet to port 2 then len-1 packet to port 0.
    b0 = cnt_we0; b2 = cnt_we2;
    send_pkt(8'h02, 8'h00);
    send_pkt(8'h04, 8'h00);
    idle(3);
    chk("b2b port2 writes", 32'(cnt_we2 - b2), 32'd2);
    chk("b2b port0 writes", 32'(cnt_we0 - b0), 32'd3);
    chk("b2b err", 32'(err), 32'd0);
    check_queues("b2b");

    // Reset in the middle of a payload.
    send_pkt(8'h02, 8'h55);
    send(8'h39, 3'b000);
    for (int i = 0; i < 3; i++) send(8'(i), 3'b000);
    resetn = 1'b1;
    idle(2);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid reset write_enb", 32'(write_enb), 32'd0);
    chk("mid reset data_out", 32'(data_out), 32'd0);
    chk("mid reset err", 32'(err), 32'd0);
    chk("mid reset lfd", 32'(lfd_state), 32'd0);
    @(posedge clk); #1;
    b2 = cnt_we2;
    send_pkt(8'h02, 8'h00);
    idle(3);
    chk("post reset port2 writes", 32'(cnt_we2 - b2), 32'd2);
    check_queues("post reset");

    // Random traffic with gaps and random full flags.
    for (int k = 0; k < 150; k++) begin
      len  = 8'($urandom_range(0, 8));
      addr = 8'($urandom_range(0, 3));
      hdr  = {len[5:0], addr[1:0]};
      p    = hdr;
      for (int j = 0; j <= int'(len) + 1; j++) begin
        if (j == 0) d = hdr;
        else if (j <= int'(len)) begin d = 8'($urandom); p = p ^ d; end
        else d = ($urandom_range(0, 3) == 0) ? (p ^ 8'($urandom_range(1, 255))) : p;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
          f = {3{1'b0}};
          for (int q = 0; q < 3; q++) f[q] = ($urandom_range(0, 3) == 0);
          tick($urandom_range(0, 3) != 0, d, f, acc);
        end
        if (!acc) chk("random send timeout", 32'd0, 32'd1);
      end
    end
    idle(4);
    check_queues("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
